// File: rtl/multiply_accumulate_unit.sv
// Iterative multiply-accumulate unit for the ALU execute stage.
// Covers MUL, MLA, UMULL, UMLAL, SMULL and SMLAL. One multiplier byte is
// consumed per cycle with ARM7TDMI-style early termination, followed by an
// optional accumulate cycle and an optional long-form cycle.
//
// Handshake: start is sampled only when the unit is idle or in its done
// cycle; busy is high for the whole operation and done pulses for one cycle
// on the edge busy falls. Results and flags are registered on that edge and
// hold until the next done. There is no backpressure.
module multiply_accumulate_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] rm,
  input  logic [31:0] rs,
  input  logic [31:0] rnLo,
  input  logic [31:0] rnHi,
  input  logic        accumulate,
  input  logic        longMultiply,
  input  logic        signedMultiply,
  input  logic        carryFlag,
  output logic        busy,
  output logic        done,
  output logic [31:0] resultLo,
  output logic [31:0] resultHi,
  output logic        newNegativeFlag,
  output logic        newZeroFlag,
  output logic        newCarryFlag
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] MUL  = 3'd1;
  localparam logic [2:0] ACC  = 3'd2;
  localparam logic [2:0] LONG = 3'd3;
  localparam logic [2:0] FIN  = 3'd4;

  logic [2:0]  state;
  logic [2:0]  nextState;

  // Captured operands and mode bits
  logic [31:0] rmReg;
  logic [31:0] rsReg;
  logic [31:0] rnLoReg;
  logic [31:0] rnHiReg;
  logic        accumulateReg;
  logic        longReg;
  logic        signedReg;
  logic        tolerantReg;
  logic        carryReg;

  // Iteration control: iter counts bytes, lastIdx is m-1
  logic [1:0]  iter;
  logic [1:0]  lastIdx;
  logic [1:0]  lastIdxIn;
  logic        tolerantIn;

  logic [63:0] acc;
  logic [63:0] accNext;

  logic               accept;
  logic [31:0]        rsShift;
  logic [7:0]         rsByte;
  logic signed [32:0] rmExt;
  logic signed [8:0]  byteExt;
  logic signed [41:0] product;
  logic [63:0]        ppWide;
  logic [63:0]        partial;

  assign accept = start && ((state == IDLE) || (state == FIN));
  assign busy   = (state == MUL) || (state == ACC) || (state == LONG);
  assign done   = (state == FIN);

  // Early-termination count from the incoming multiplier; unsigned long
  // forms only terminate on leading zero bytes, the rest also on leading ones.
  always_comb begin
    tolerantIn = !longMultiply || signedMultiply;
    if (!(|rs[31:8]) || (tolerantIn && (&rs[31:8])))
      lastIdxIn = 2'd0;
    else if (!(|rs[31:16]) || (tolerantIn && (&rs[31:16])))
      lastIdxIn = 2'd1;
    else if (!(|rs[31:24]) || (tolerantIn && (&rs[31:24])))
      lastIdxIn = 2'd2;
    else
      lastIdxIn = 2'd3;
  end

  // Partial product: extended multiplicand times the current multiplier
  // byte, which is signed only for the final byte of a sign-tolerant mode.
  always_comb begin
    rmExt   = {signedReg & longReg & rmReg[31], rmReg};
    rsShift = rsReg >> {iter, 3'b000};
    rsByte  = rsShift[7:0];
    byteExt = {tolerantReg && (iter == lastIdx) && rsByte[7], rsByte};
    product = rmExt * byteExt;
    ppWide  = {{22{product[41]}}, product};
    partial = ppWide << {iter, 3'b000};
  end

  // Accumulator update for the current state (modulo 2^64)
  always_comb begin
    accNext = acc;
    case (state)
      MUL:     accNext = acc + partial;
      ACC:     accNext = acc + (longReg ? {rnHiReg, rnLoReg} : {32'b0, rnLoReg});
      default: accNext = acc;
    endcase
  end

  // Sequencer next-state logic
  always_comb begin
    nextState = IDLE;
    case (state)
      IDLE:    nextState = start ? MUL : IDLE;
      MUL: begin
        if (iter != lastIdx) nextState = MUL;
        else if (accumulateReg) nextState = ACC;
        else if (longReg) nextState = LONG;
        else nextState = FIN;
      end
      ACC:     nextState = longReg ? LONG : FIN;
      LONG:    nextState = FIN;
      FIN:     nextState = start ? MUL : IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State, operand capture, accumulator and registered results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      rmReg           <= '0;
      rsReg           <= '0;
      rnLoReg         <= '0;
      rnHiReg         <= '0;
      accumulateReg   <= 1'b0;
      longReg         <= 1'b0;
      signedReg       <= 1'b0;
      tolerantReg     <= 1'b0;
      carryReg        <= 1'b0;
      iter            <= '0;
      lastIdx         <= '0;
      acc             <= '0;
      resultLo        <= '0;
      resultHi        <= '0;
      newNegativeFlag <= 1'b0;
      newZeroFlag     <= 1'b0;
      newCarryFlag    <= 1'b0;
    end else begin
      state <= nextState;
      if (accept) begin
        rmReg         <= rm;
        rsReg         <= rs;
        rnLoReg       <= rnLo;
        rnHiReg       <= rnHi;
        accumulateReg <= accumulate;
        longReg       <= longMultiply;
        signedReg     <= signedMultiply;
        tolerantReg   <= tolerantIn;
        carryReg      <= carryFlag;
        lastIdx       <= lastIdxIn;
        iter          <= '0;
        acc           <= '0;
      end else begin
        acc <= accNext;
        if (state == MUL) iter <= iter + 2'd1;
      end
      // Results land on the edge that ends the busy window
      if (busy && (nextState == FIN)) begin
        resultLo     <= accNext[31:0];
        newCarryFlag <= carryReg;
        if (longReg) begin
          resultHi        <= accNext[63:32];
          newNegativeFlag <= accNext[63];
          newZeroFlag     <= (accNext == 64'd0);
        end else begin
          resultHi        <= '0;
          newNegativeFlag <= accNext[31];
          newZeroFlag     <= (accNext[31:0] == 32'd0);
        end
      end
    end
  end

endmodule

// File: tb/tb_multiply_accumulate_unit.sv
// Directed bench for multiply_accumulate_unit: a table of hand-computed
// vectors plus sequences for held start, back-to-back and mid-op reset.
module tb_multiply_accumulate_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] rm, rs, rnLo, rnHi;
  logic        accumulate, longMultiply, signedMultiply, carryFlag;
  logic        busy, done;
  logic [31:0] resultLo, resultHi;
  logic        newNegativeFlag, newZeroFlag, newCarryFlag;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic [31:0] vRm;
    logic [31:0] vRs;
    logic [31:0] vRnLo;
    logic [31:0] vRnHi;
    logic        vAcc;
    logic        vLong;
    logic        vSigned;
    logic        vCarry;
    int          expBusy;
    logic [31:0] expLo;
    logic [31:0] expHi;
    logic        expN;
    logic        expZ;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs[NVEC];

  multiply_accumulate_unit dut (
    .clk(clk), .reset(reset), .start(start),
    .rm(rm), .rs(rs), .rnLo(rnLo), .rnHi(rnHi),
    .accumulate(accumulate), .longMultiply(longMultiply),
    .signedMultiply(signedMultiply), .carryFlag(carryFlag),
    .busy(busy), .done(done), .resultLo(resultLo), .resultHi(resultHi),
    .newNegativeFlag(newNegativeFlag), .newZeroFlag(newZeroFlag),
    .newCarryFlag(newCarryFlag)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one operation starting now (caller is away from a rising edge),
  // counts busy cycles with a bound, then checks the done-cycle outputs.
  task automatic runOp(input string tag, input vec_t v);
    int cnt;
    rm = v.vRm; rs = v.vRs; rnLo = v.vRnLo; rnHi = v.vRnHi;
    accumulate = v.vAcc; longMultiply = v.vLong;
    signedMultiply = v.vSigned; carryFlag = v.vCarry;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rm = 32'hA5A5A5A5; rs = 32'h5A5A5A5A; rnLo = 32'hDEADBEEF; rnHi = 32'hCAFEF00D;
    carryFlag = ~v.vCarry;
    cnt = 0;
    while (busy && cnt < 20) begin
      cnt++;
      @(posedge clk); #1;
    end
    check({tag, " busy cycles"}, 64'(cnt), 64'(v.expBusy));
    check({tag, " done"}, {63'b0, done}, 64'd1);
    check({tag, " result"}, {resultHi, resultLo}, {v.expHi, v.expLo});
    check({tag, " flags NZC"}, {61'b0, newNegativeFlag, newZeroFlag, newCarryFlag},
          {61'b0, v.expN, v.expZ, v.vCarry});
  endtask

  initial begin
    int doneCount;
    int firstDone;
    vec_t v;

    //            rm            rs            rnLo          rnHi          A  L  S  C  busy lo            hi            N  Z
    vecs[0]  = '{32'd7,        32'd6,        32'd0,        32'd0,        0, 0, 0, 0, 1, 32'd42,       32'd0,        0, 0};
    vecs[1]  = '{32'h12345678, 32'h00010000, 32'd0,        32'd0,        0, 0, 0, 1, 3, 32'h56780000, 32'd0,        0, 0};
    vecs[2]  = '{32'd5,        32'hFFFFFFFF, 32'd0,        32'd0,        0, 1, 1, 0, 2, 32'hFFFFFFFB, 32'hFFFFFFFF, 1, 0};
    vecs[3]  = '{32'hFFFFFFFE, 32'd3,        32'd0,        32'd0,        0, 1, 1, 1, 2, 32'hFFFFFFFA, 32'hFFFFFFFF, 1, 0};
    vecs[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd0,        0, 1, 0, 0, 5, 32'h00000001, 32'hFFFFFFFE, 1, 0};
    vecs[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1, 1, 0, 1, 6, 32'h00000000, 32'hFFFFFFFF, 1, 0};
    vecs[6]  = '{32'd3,        32'd4,        32'd10,       32'h0000DEAD, 1, 0, 0, 0, 2, 32'd22,       32'd0,        0, 0};
    vecs[7]  = '{32'd3,        32'hFFFFFFFE, 32'd0,        32'd0,        0, 0, 0, 1, 1, 32'hFFFFFFFA, 32'd0,        1, 0};
    vecs[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5,        32'd0,        1, 1, 1, 0, 3, 32'd6,        32'd0,        0, 0};
    vecs[9]  = '{32'h80000000, 32'h80000000, 32'd0,        32'd0,        0, 1, 1, 1, 5, 32'd0,        32'h40000000, 0, 0};
    vecs[10] = '{32'h10,       32'h100,      32'd0,        32'd0,        0, 1, 0, 0, 3, 32'h1000,     32'd0,        0, 0};
    vecs[11] = '{32'd2,        32'hFFFF8000, 32'd0,        32'd0,        0, 0, 0, 1, 2, 32'hFFFF0000, 32'd0,        1, 0};
    vecs[12] = '{32'h10000,    32'h10000,    32'd0,        32'd0,        0, 0, 0, 0, 3, 32'd0,        32'd0,        0, 1};
    vecs[13] = '{32'd5,        32'hFFFFFFFF, 32'd0,        32'd0,        0, 1, 0, 1, 5, 32'hFFFFFFFB, 32'h00000004, 0, 0};
    vecs[14] = '{32'd0,        32'd0,        32'd0,        32'd0,        0, 1, 0, 0, 2, 32'd0,        32'd0,        0, 1};

    // Reset
    reset = 1'b1; start = 1'b0;
    rm = '0; rs = '0; rnLo = '0; rnHi = '0;
    accumulate = 0; longMultiply = 0; signedMultiply = 0; carryFlag = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {25'b0, busy, done, newNegativeFlag, newZeroFlag, newCarryFlag, resultLo | resultHi},
          64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table: each operation starts in the done cycle of the previous one
    for (int i = 0; i < NVEC; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i]);
    end
    @(posedge clk); #1;
    check("done single pulse", {63'b0, done}, 64'd0);
    check("results hold", {resultHi, resultLo}, {vecs[NVEC-1].expHi, vecs[NVEC-1].expLo});

    // MLA with start held four edges: second accept only in the done cycle
    rm = 32'd0; rs = 32'd5; rnLo = 32'd0; rnHi = 32'd0;
    accumulate = 1; longMultiply = 0; signedMultiply = 0; carryFlag = 1;
    start = 1'b1;
    doneCount = 0; firstDone = 0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      if (e == 4) start = 1'b0;
      if (done) begin
        doneCount++;
        if (firstDone == 0) firstDone = e;
      end
    end
    check("held start done count", 64'(doneCount), 64'd2);
    check("held start first done edge", 64'(firstDone), 64'd3);
    check("MLA zero result", {resultHi, resultLo}, 64'd0);
    check("MLA flags NZC", {61'b0, newNegativeFlag, newZeroFlag, newCarryFlag}, 64'b011);

    // Reset in busy cycle 2 of a 5-cycle UMULL
    rm = 32'h12345; rs = 32'hFFFFFFFF; accumulate = 0; longMultiply = 1;
    signedMultiply = 0; carryFlag = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("busy before reset", {63'b0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    check("mid-op reset outputs", {25'b0, busy, done, newNegativeFlag, newZeroFlag, newCarryFlag, resultLo | resultHi},
          64'd0);
    @(negedge clk);
    reset = 1'b0;
    v = '{32'd3, 32'd4, 32'd0, 32'd0, 0, 0, 0, 0, 1, 32'd12, 32'd0, 0, 0};
    runOp("post-reset MUL", v);
    doneCount = 0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
      if (done) doneCount++;
    end
    check("no stray done after reset", 64'(doneCount), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
